uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
Frame parser between the UART receiver output (rx_dv/rx_byte) and the command-processing FSM.
- Turns the raw byte stream into validated command frames: SOF, CMD, LEN, payload, XOR checksum.
- Presents one command plus a buffered payload to the consumer through a valid/ready handshake.
- Reports framing errors as a one-cycle pulse with a code.
- Replaces single-byte command decoding so multi-byte commands from the Pico are possible.

Parameters:
CLK_FREQ_HZ, 25_000_000, system clock frequency.
BAUD_RATE, 115200, UART line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (217).
MAX_PAYLOAD, 8, maximum payload bytes per frame (1..255).
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_BYTES, 4, inter-byte timeout in byte times; TIMEOUT_CLKS = CLKS_PER_BIT*10*TIMEOUT_BYTES (8680).

Ports:
i_clk  in  1  system clock; single clock domain.
i_rst  in  1  reset, synchronous, active-high.
i_rx_dv  in  1  one-cycle strobe: i_rx_byte is valid.
i_rx_byte  in  8  received byte.
o_cmd_valid  out  1  a validated frame is held on the outputs.
i_cmd_ready  in  1  consumer accepts the frame; transfer occurs when valid & ready.
o_cmd  out  8  command byte of the held frame.
o_len  out  LW=$clog2(MAX_PAYLOAD+1)  payload length of the held frame.
i_rd_addr  in  $clog2(MAX_PAYLOAD)  payload read index.
o_rd_data  out  8  payload[i_rd_addr]; combinational read, valid while o_cmd_valid.
o_err  out  1  one-cycle error pulse.
o_err_code  out  3  error cause; updated with o_err and held until the next error.
o_busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset values (i_rst high at the clock edge), for all outputs: o_cmd_valid=0, o_cmd=0, o_len=0, o_err=0, o_err_code=0, o_busy=0. Also: state=S_IDLE, checksum=0, index=0, timeout counter=0. Payload RAM contents are don't-care.
- Reset mid-frame or mid-hold aborts immediately. No o_err is raised and the partial frame is discarded.
- States: S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD.
- S_IDLE: on i_rx_dv with i_rx_byte==SOF_BYTE, go to S_CMD and clear the checksum. Any other byte is silently dropped.
- S_CMD: on i_rx_dv, latch cmd, set chk=byte, go to S_LEN.
- S_LEN: on i_rx_dv:
  - byte > MAX_PAYLOAD: error code 1 (BAD_LEN), go to S_IDLE.
  - byte == 0: go to S_CHK.
  - otherwise: go to S_PAY with index=0.
  - In all cases chk ^= byte and len is latched.
- S_PAY: on i_rx_dv, write buf[index]=byte, chk ^= byte, index++. When index==len-1 is being written, go to S_CHK.
- S_CHK: on i_rx_dv:
  - byte==chk: load o_cmd/o_len, set o_cmd_valid=1, go to S_HOLD.
  - otherwise: error code 2 (BAD_CHK), go to S_IDLE.
- Latency: the checksum byte strobes at cycle N; o_cmd_valid (or o_err) is high at cycle N+1.
- S_HOLD: o_cmd_valid stays high and outputs are stable until i_cmd_ready. At the cycle valid&ready is sampled, o_cmd_valid drops the next cycle and the state returns to S_IDLE.
- Overrun: any i_rx_dv in S_HOLD drops the byte and pulses error code 4 (OVERRUN). The held frame is unaffected.
- Timeout: in S_CMD, S_LEN, S_PAY and S_CHK the counter increments every cycle and clears on i_rx_dv. On reaching TIMEOUT_CLKS-1, pulse error code 3 (TIMEOUT) and go to S_IDLE. If i_rx_dv arrives in the same cycle as expiry, the byte wins and no timeout occurs.
- The SOF value appearing inside CMD, LEN, payload or checksum is treated as data; there is no resynchronisation.
- o_err is exactly one cycle per error event. At most one error per cycle is possible by construction.
- Checksum: 8-bit XOR over CMD, LEN and all payload bytes.

Decomposition:
- Package uart_frame_pkg holds:
  - frm_state_t enum.
  - err_code_t enum: ERR_NONE=0, ERR_BAD_LEN=1, ERR_BAD_CHK=2, ERR_TIMEOUT=3, ERR_OVERRUN=4.
  - Default SOF_BYTE constant.
  - A function computing TIMEOUT_CLKS.
- One sub-module, frame_payload_buf: MAX_PAYLOAD x 8 register file with a synchronous write port and an asynchronous read port.

Test Plan:
- A5 01 00 01 -> o_cmd_valid one cycle after the last byte; o_cmd=01, o_len=0, no o_err. With i_cmd_ready held 1, valid is high for exactly one cycle.
- A5 10 02 33 44 65 with i_cmd_ready=0 -> valid held; o_len=2, rd_addr 0->33, 1->44. Asserting ready 20 cycles later drops valid on the next cycle.
- A5 10 02 33 44 66 -> o_err pulse with code 2, no valid; a following good frame A5 01 00 01 parses correctly.
- A5 07 09 -> code 1 one cycle after the LEN byte. Then A5 07 01 ... with a gap of 8680 idle cycles -> code 3 exactly at expiry, state back to S_IDLE.
- Frame held (ready=0), send byte 5A -> code 4 pulse; o_cmd/o_len/payload unchanged.
- Noise 00 FF 12, then reset asserted during S_PAY of a frame -> all outputs zero, no o_err; the next full frame parses correctly.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
//   frm_state_t  : parser FSM states
//   err_code_t   : framing error causes reported on o_err_code
//   SOF_BYTE_DEFAULT, timeout_clks() : default marker and timeout length helper
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CHK  = 3'd4,
        S_HOLD = 3'd5
    } frm_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BAD_LEN = 3'd1,
        ERR_BAD_CHK = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } err_code_t;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    // Inter-byte timeout in clocks: one byte time is 10 bit times (start + 8 data + stop).
    function automatic int unsigned timeout_clks(input int unsigned clk_hz,
                                                 input int unsigned baud,
                                                 input int unsigned n_bytes);
        return (clk_hz / baud) * 10 * n_bytes;
    endfunction

endpackage

// File: rtl/frame_payload_buf.sv
// Payload register file for one command frame.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_raddr/o_rdata  : asynchronous read port
module frame_payload_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem [DEPTH];

    // Contents need no reset: they are only read while a validated frame is held.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser: SOF, CMD, LEN, payload, XOR checksum -> held command with valid/ready.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_rx_dv, i_rx_byte    : byte strobe from the UART receiver
//   o_cmd_valid, i_cmd_ready, o_cmd, o_len : held frame and handshake
//   i_rd_addr, o_rd_data  : combinational payload read port
//   o_err, o_err_code     : one-cycle error pulse and sticky cause
//   o_busy                : parser is not idle
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 25_000_000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned MAX_PAYLOAD   = 8,
    parameter logic [7:0]  SOF_BYTE      = SOF_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_BYTES = 4,
    localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1),
    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx_dv,
    input  logic [7:0]    i_rx_byte,
    output logic          o_cmd_valid,
    input  logic          i_cmd_ready,
    output logic [7:0]    o_cmd,
    output logic [LW-1:0] o_len,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_err,
    output logic [2:0]    o_err_code,
    output logic          o_busy
);

    localparam int unsigned TIMEOUT_CLKS = timeout_clks(CLK_FREQ_HZ, BAUD_RATE, TIMEOUT_BYTES);
    localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    frm_state_t    state_q, state_d;
    logic [7:0]    chk_q, chk_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_lat_q, cmd_lat_d;
    logic [LW-1:0] len_lat_q, len_lat_d;
    logic          valid_q, valid_d;
    logic [7:0]    out_cmd_q, out_cmd_d;
    logic [LW-1:0] out_len_q, out_len_d;
    logic          err_q, err_d;
    err_code_t     err_code_q, err_code_d;
    logic          busy_q;
    logic          wr_en_c;

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            chk_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cmd_lat_q  <= '0;
            len_lat_q  <= '0;
            valid_q    <= 1'b0;
            out_cmd_q  <= '0;
            out_len_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cmd_lat_q  <= cmd_lat_d;
            len_lat_q  <= len_lat_d;
            valid_q    <= valid_d;
            out_cmd_q  <= out_cmd_d;
            out_len_q  <= out_len_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cmd_lat_d  = cmd_lat_q;
        len_lat_d  = len_lat_q;
        valid_d    = valid_q;
        out_cmd_d  = out_cmd_q;
        out_len_d  = out_len_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wr_en_c    = 1'b0;

        // Inter-byte timeout; a byte arriving on the expiry cycle takes priority.
        if (state_q inside {S_CMD, S_LEN, S_PAY, S_CHK}) begin
            if (i_rx_dv) begin
                cnt_d = '0;
            end else if (cnt_q == TW'(TIMEOUT_CLKS - 1)) begin
                cnt_d      = '0;
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
                state_d    = S_IDLE;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_rx_dv && (i_rx_byte == SOF_BYTE)) begin
                    chk_d   = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (i_rx_dv) begin
                    cmd_lat_d = i_rx_byte;
                    chk_d     = i_rx_byte;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_dv) begin
                    chk_d     = chk_q ^ i_rx_byte;
                    len_lat_d = LW'(i_rx_byte);
                    idx_d     = '0;
                    if (i_rx_byte > 8'(MAX_PAYLOAD)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_LEN;
                        state_d    = S_IDLE;
                    end else if (i_rx_byte == 8'h00) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (i_rx_dv) begin
                    wr_en_c = 1'b1;
                    chk_d   = chk_q ^ i_rx_byte;
                    idx_d   = idx_q + AW'(1);
                    if (LW'(idx_q) == (len_lat_q - LW'(1))) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == chk_q) begin
                        out_cmd_d = cmd_lat_q;
                        out_len_d = len_lat_q;
                        valid_d   = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_CHK;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // Bytes arriving while a frame is held are dropped, never written.
                if (i_rx_dv) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (i_cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    frame_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_payload_buf (
        .i_clk   (i_clk),
        .i_we    (wr_en_c),
        .i_waddr (idx_q),
        .i_wdata (i_rx_byte),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

    assign o_cmd_valid = valid_q;
    assign o_cmd       = out_cmd_q;
    assign o_len       = out_len_q;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with hand-computed frames and checksums.
module tb_uart_frame_rx;

    localparam int unsigned TC = 8680;

    logic       i_clk;
    logic       i_rst;
    logic       i_rx_dv;
    logic [7:0] i_rx_byte;
    logic       o_cmd_valid;
    logic       i_cmd_ready;
    logic [7:0] o_cmd;
    logic [3:0] o_len;
    logic [2:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic       o_err;
    logic [2:0] o_err_code;
    logic       o_busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int err_pulses = 0;
    int e0 = 0;

    uart_frame_rx dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_dv     (i_rx_dv),
        .i_rx_byte   (i_rx_byte),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd       (o_cmd),
        .o_len       (o_len),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Counts o_err high cycles, sampled shortly after each rising edge.
    always @(posedge i_clk) begin
        #1;
        if (o_err === 1'b1) err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge
    // and the task returns at the falling edge after it.
    task automatic send_byte(input logic [7:0] b);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(negedge i_clk);
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_rx_dv     = 1'b0;
        i_rx_byte   = 8'h00;
        i_cmd_ready = 1'b0;
        i_rd_addr   = 3'd0;
        repeat (3) @(negedge i_clk);
        check_eq("rst_valid", 32'(o_cmd_valid), 0);
        check_eq("rst_cmd", 32'(o_cmd), 0);
        check_eq("rst_len", 32'(o_len), 0);
        check_eq("rst_err", 32'(o_err), 0);
        check_eq("rst_code", 32'(o_err_code), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Zero-length frame, consumer always ready: valid for exactly one cycle.
        e0 = err_pulses;
        i_cmd_ready = 1'b1;
        send_byte(8'hA5);
        check_eq("f1_busy_after_sof", 32'(o_busy), 1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        check_eq("f1_valid", 32'(o_cmd_valid), 1);
        check_eq("f1_cmd", 32'(o_cmd), 32'h01);
        check_eq("f1_len", 32'(o_len), 0);
        @(negedge i_clk);
        check_eq("f1_valid_drop", 32'(o_cmd_valid), 0);
        check_eq("f1_busy_idle", 32'(o_busy), 0);
        check_eq("f1_no_err", 32'(err_pulses - e0), 0);

        // Two-byte payload held until ready asserted 20 cycles later.
        i_cmd_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h65);
        check_eq("f2_valid", 32'(o_cmd_valid), 1);
        check_eq("f2_cmd", 32'(o_cmd), 32'h10);
        check_eq("f2_len", 32'(o_len), 2);
        i_rd_addr = 3'd0; #1;
        check_eq("f2_rd0", 32'(o_rd_data), 32'h33);
        i_rd_addr = 3'd1; #1;
        check_eq("f2_rd1", 32'(o_rd_data), 32'h44);
        repeat (20) @(negedge i_clk);
        check_eq("f2_valid_held", 32'(o_cmd_valid), 1);
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        check_eq("f2_valid_drop", 32'(o_cmd_valid), 0);
        check_eq("f2_no_err", 32'(err_pulses - e0), 0);

        // Bad checksum, then a good frame.
        i_cmd_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h66);
        check_eq("chk_err", 32'(o_err), 1);
        check_eq("chk_code", 32'(o_err_code), 2);
        check_eq("chk_no_valid", 32'(o_cmd_valid), 0);
        @(negedge i_clk);
        check_eq("chk_err_pulse", 32'(o_err), 0);
        check_eq("chk_code_held", 32'(o_err_code), 2);
        i_cmd_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        check_eq("chk_next_valid", 32'(o_cmd_valid), 1);
        check_eq("chk_next_cmd", 32'(o_cmd), 32'h01);
        @(negedge i_clk);

        // Length above MAX_PAYLOAD.
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h09);
        check_eq("len_err", 32'(o_err), 1);
        check_eq("len_code", 32'(o_err_code), 1);
        check_eq("len_busy", 32'(o_busy), 0);
        @(negedge i_clk);
        check_eq("len_pulses", 32'(err_pulses - e0), 1);

        // Timeout: silence while waiting for the payload byte.
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01);
        repeat (TC - 1) @(negedge i_clk);
        check_eq("to_not_yet", 32'(o_err), 0);
        check_eq("to_busy_before", 32'(o_busy), 1);
        @(negedge i_clk);
        check_eq("to_err", 32'(o_err), 1);
        check_eq("to_code", 32'(o_err_code), 3);
        check_eq("to_busy_after", 32'(o_busy), 0);
        check_eq("to_pulses", 32'(err_pulses - e0), 1);

        // Byte arriving on the expiry cycle wins over the timeout.
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01);
        repeat (TC - 1) @(negedge i_clk);
        send_byte(8'h05);
        check_eq("win_no_err", 32'(o_err), 0);
        send_byte(8'h03);
        check_eq("win_valid", 32'(o_cmd_valid), 1);
        check_eq("win_cmd", 32'(o_cmd), 32'h07);
        i_rd_addr = 3'd0; #1;
        check_eq("win_rd0", 32'(o_rd_data), 32'h05);
        @(negedge i_clk);
        check_eq("win_valid_drop", 32'(o_cmd_valid), 0);
        check_eq("win_pulses", 32'(err_pulses - e0), 0);

        // Maximum-length frame held, then an overrun byte.
        i_cmd_ready = 1'b0;
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h08);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h20);
        check_eq("max_valid", 32'(o_cmd_valid), 1);
        check_eq("max_cmd", 32'(o_cmd), 32'h20);
        check_eq("max_len", 32'(o_len), 8);
        check_eq("max_no_err", 32'(err_pulses - e0), 0);
        i_rd_addr = 3'd7; #1;
        check_eq("max_rd7", 32'(o_rd_data), 32'h08);
        @(negedge i_clk);
        send_byte(8'h5A);
        check_eq("ovr_err", 32'(o_err), 1);
        check_eq("ovr_code", 32'(o_err_code), 4);
        check_eq("ovr_valid", 32'(o_cmd_valid), 1);
        check_eq("ovr_cmd", 32'(o_cmd), 32'h20);
        check_eq("ovr_len", 32'(o_len), 8);
        i_rd_addr = 3'd0; #1;
        check_eq("ovr_rd0", 32'(o_rd_data), 32'h01);
        @(negedge i_clk);
        check_eq("ovr_err_pulse", 32'(o_err), 0);
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        check_eq("ovr_release", 32'(o_cmd_valid), 0);

        // Noise, then reset in the middle of a payload.
        i_cmd_ready = 1'b0;
        e0 = err_pulses;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        check_eq("noise_busy", 32'(o_busy), 0);
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_eq("mrst_valid", 32'(o_cmd_valid), 0);
        check_eq("mrst_cmd", 32'(o_cmd), 0);
        check_eq("mrst_len", 32'(o_len), 0);
        check_eq("mrst_err", 32'(o_err), 0);
        check_eq("mrst_code", 32'(o_err_code), 0);
        check_eq("mrst_busy", 32'(o_busy), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h33);
        check_eq("post_valid", 32'(o_cmd_valid), 1);
        check_eq("post_cmd", 32'(o_cmd), 32'h30);
        check_eq("post_len", 32'(o_len), 3);
        i_rd_addr = 3'd2; #1;
        check_eq("post_rd2", 32'(o_rd_data), 32'h33);
        i_rd_addr = 3'd0; #1;
        check_eq("post_rd0", 32'(o_rd_data), 32'h11);
        check_eq("post_no_err", 32'(err_pulses - e0), 0);
        @(negedge i_clk);
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        check_eq("post_release", 32'(o_cmd_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
